// File: rtl/fetch_control_pkg.sv
// Shared definitions for the fetch-stage controller: default widths,
// register-index width and the sequencing state encoding.
package fetch_control_pkg;

  localparam int PC_W_DEF  = 11;
  localparam int CNT_W_DEF = 16;
  localparam int REG_W     = 5;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_STEP_WAIT = 2'd1,
    ST_STEP_GO   = 2'd2,
    ST_HALT      = 2'd3
  } state_t;

  // A state lets the pipeline move only while free running or on a granted step.
  function automatic logic is_advance(input state_t st);
    return (st == ST_RUN) || (st == ST_STEP_GO);
  endfunction

endpackage

// File: rtl/fetch_control_if.sv
// Pipeline-side signal bundle of the fetch controller. The master side
// supplies hazard/branch/debug information; the slave side (the
// controller) returns fetch-stage controls and statistics.
interface fetch_control_if
  import fetch_control_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
);

  logic             id_ex_mem_read;
  logic [REG_W-1:0] id_ex_rt;
  logic [REG_W-1:0] if_id_rs;
  logic [REG_W-1:0] if_id_rt;
  logic             branch_taken;
  logic [PC_W-1:0]  branch_target;
  logic             halt_detected;
  logic             step_mode;
  logic             step_pulse;

  logic             pc_write;
  logic             if_id_write;
  logic             if_flush;
  logic             salto_sel;
  logic [PC_W-1:0]  pc_salto;
  logic             id_ex_bubble;
  logic             halted;
  logic [CNT_W-1:0] cycle_count;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt,
    output branch_taken, branch_target, halt_detected, step_mode, step_pulse,
    input  pc_write, if_id_write, if_flush, salto_sel, pc_salto,
    input  id_ex_bubble, halted, cycle_count, stall_count
  );

  modport slave (
    input  id_ex_mem_read, id_ex_rt, if_id_rs, if_id_rt,
    input  branch_taken, branch_target, halt_detected, step_mode, step_pulse,
    output pc_write, if_id_write, if_flush, salto_sel, pc_salto,
    output id_ex_bubble, halted, cycle_count, stall_count
  );

endinterface

// File: rtl/fetch_control_hazard_detect.sv
// Load-use hazard comparator: the load in EX writes a register the
// instruction in ID reads. Register 0 is hardwired and never hazards.
module hazard_detect
  import fetch_control_pkg::*;
(
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  output logic             load_use
);

  assign load_use = id_ex_mem_read &&
                    (id_ex_rt != {REG_W{1'b0}}) &&
                    ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

endmodule

// File: rtl/fetch_control.sv
// Fetch-stage controller: arbitrates HALT, taken branches and load-use
// stalls, sequences debug single-step, and keeps cycle/stall statistics.
module fetch_control
  import fetch_control_pkg::*;
#(
  parameter int PC_W  = PC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
)(
  input  logic           clock,
  input  logic           reset_n,
  fetch_control_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           next_s;
  logic             halted_r;
  logic [CNT_W-1:0] cycle_r;
  logic [CNT_W-1:0] stall_r;

  logic             load_use_s;
  logic             advance_s;
  logic             stall_sel_s;
  logic             pc_write_s;
  logic             if_id_write_s;
  logic             if_flush_s;
  logic             salto_sel_s;
  logic             bubble_s;
  logic [PC_W-1:0]  pc_salto_s;

  hazard_detect u_hazard (
    .id_ex_mem_read (bus.id_ex_mem_read),
    .id_ex_rt       (bus.id_ex_rt),
    .if_id_rs       (bus.if_id_rs),
    .if_id_rt       (bus.if_id_rt),
    .load_use       (load_use_s)
  );

  assign advance_s = is_advance(state_r);

  // Select this cycle's fetch action: freeze > branch redirect > load-use stall > normal.
  always_comb begin
    pc_write_s    = 1'b0;
    if_id_write_s = 1'b0;
    if_flush_s    = 1'b0;
    salto_sel_s   = 1'b0;
    bubble_s      = 1'b1;
    stall_sel_s   = 1'b0;
    pc_salto_s    = {PC_W{1'b0}};
    if (!advance_s || bus.halt_detected) begin
      // frozen: not an advance cycle, or HALT reached ID (no redirect)
      bubble_s = 1'b1;
    end else if (bus.branch_taken) begin
      pc_write_s    = 1'b1;
      if_id_write_s = 1'b1;
      if_flush_s    = 1'b1;
      salto_sel_s   = 1'b1;
      bubble_s      = 1'b0;
      pc_salto_s    = bus.branch_target;
    end else if (load_use_s) begin
      stall_sel_s = 1'b1;
    end else begin
      pc_write_s    = 1'b1;
      if_id_write_s = 1'b1;
      bubble_s      = 1'b0;
    end
  end

  // Next sequencing state: HALT in an advance cycle dominates; otherwise step handshake.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (bus.halt_detected)  next_s = ST_HALT;
        else if (bus.step_mode) next_s = ST_STEP_WAIT;
        else                    next_s = ST_RUN;
      end
      ST_STEP_WAIT: begin
        if (!bus.step_mode)      next_s = ST_RUN;
        else if (bus.step_pulse) next_s = ST_STEP_GO;
        else                     next_s = ST_STEP_WAIT;
      end
      ST_STEP_GO: begin
        if (bus.halt_detected)  next_s = ST_HALT;
        else if (bus.step_mode) next_s = ST_STEP_WAIT;
        else                    next_s = ST_RUN;
      end
      ST_HALT: next_s = ST_HALT;
      default: next_s = ST_RUN;
    endcase
  end

  // Sequencing state register with registered halted flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_RUN;
      halted_r <= 1'b0;
    end else begin
      state_r  <= next_s;
      halted_r <= (next_s == ST_HALT);
    end
  end

  // Saturating statistics: live cycles and cycles spent on load-use stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cycle_r <= {CNT_W{1'b0}};
      stall_r <= {CNT_W{1'b0}};
    end else begin
      if ((state_r != ST_HALT) && (cycle_r != CNT_MAX)) cycle_r <= cycle_r + CNT_ONE;
      else                                               cycle_r <= cycle_r;
      if (stall_sel_s && (stall_r != CNT_MAX)) stall_r <= stall_r + CNT_ONE;
      else                                     stall_r <= stall_r;
    end
  end

  assign bus.pc_write     = pc_write_s;
  assign bus.if_id_write  = if_id_write_s;
  assign bus.if_flush     = if_flush_s;
  assign bus.salto_sel    = salto_sel_s;
  assign bus.pc_salto     = pc_salto_s;
  assign bus.id_ex_bubble = bubble_s;
  assign bus.halted       = halted_r;
  assign bus.cycle_count  = cycle_r;
  assign bus.stall_count  = stall_r;

endmodule

// File: tb/tb_fetch_control.sv
// Self-checking bench for fetch_control: directed scenarios plus a random
// run, all checked against a cycle-level behavioural model.
module tb_fetch_control;

  logic clock;
  logic reset_n;
  int   errors;
  int   checks;

  fetch_control_if #(.PC_W(11), .CNT_W(16)) bus ();
  fetch_control_if #(.PC_W(11), .CNT_W(4))  bus4 ();

  fetch_control #(.PC_W(11), .CNT_W(16)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  fetch_control #(.PC_W(11), .CNT_W(4))  dut4 (.clock(clock), .reset_n(reset_n), .bus(bus4));

  // small-counter instance sees the same pipeline stimulus
  assign bus4.id_ex_mem_read = bus.id_ex_mem_read;
  assign bus4.id_ex_rt       = bus.id_ex_rt;
  assign bus4.if_id_rs       = bus.if_id_rs;
  assign bus4.if_id_rt       = bus.if_id_rt;
  assign bus4.branch_taken   = bus.branch_taken;
  assign bus4.branch_target  = bus.branch_target;
  assign bus4.halt_detected  = bus.halt_detected;
  assign bus4.step_mode      = bus.step_mode;
  assign bus4.step_pulse     = bus.step_pulse;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // behavioural model: mode of operation plus unbounded event tallies
  localparam int M_FREE = 0, M_WAIT = 1, M_GO = 2, M_HALT = 3;
  localparam int A_FREEZE = 0, A_BRANCH = 1, A_STALL = 2, A_NORMAL = 3;
  int m_mode, m_cycles, m_stalls, m_act;

  logic        e_pc_write, e_if_id_write, e_if_flush, e_salto_sel, e_bubble, e_halted;
  logic [10:0] e_pc_salto;
  logic [15:0] e_cycle, e_stall16;
  logic [3:0]  e_stall4;

  task automatic predict();
    bit may_move, hazard;
    may_move = (m_mode == M_FREE) || (m_mode == M_GO);
    hazard = bus.id_ex_mem_read && (bus.id_ex_rt != 5'd0) &&
             ((bus.id_ex_rt == bus.if_id_rs) || (bus.id_ex_rt == bus.if_id_rt));
    if (!may_move || bus.halt_detected) m_act = A_FREEZE;
    else if (bus.branch_taken)          m_act = A_BRANCH;
    else if (hazard)                    m_act = A_STALL;
    else                                m_act = A_NORMAL;
    e_pc_write    = (m_act == A_BRANCH) || (m_act == A_NORMAL);
    e_if_id_write = e_pc_write;
    e_if_flush    = (m_act == A_BRANCH);
    e_salto_sel   = (m_act == A_BRANCH);
    e_pc_salto    = (m_act == A_BRANCH) ? bus.branch_target : 11'd0;
    e_bubble      = (m_act == A_FREEZE) || (m_act == A_STALL);
    e_halted      = (m_mode == M_HALT);
    e_cycle       = (m_cycles > 65535) ? 16'hFFFF : m_cycles[15:0];
    e_stall16     = (m_stalls > 65535) ? 16'hFFFF : m_stalls[15:0];
    e_stall4      = (m_stalls > 15) ? 4'hF : m_stalls[3:0];
  endtask

  task automatic settle();
    #1;
    predict();
  endtask

  // one clock: advance the model alongside the DUT, end on the next falling edge
  task automatic tick();
    predict();
    @(posedge clock);
    if (m_mode != M_HALT) m_cycles++;
    if (m_act == A_STALL) m_stalls++;
    if (((m_mode == M_FREE) || (m_mode == M_GO)) && bus.halt_detected) m_mode = M_HALT;
    else if (m_mode == M_FREE) m_mode = bus.step_mode ? M_WAIT : M_FREE;
    else if (m_mode == M_WAIT) m_mode = !bus.step_mode ? M_FREE : (bus.step_pulse ? M_GO : M_WAIT);
    else if (m_mode == M_GO)   m_mode = bus.step_mode ? M_WAIT : M_FREE;
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    bus.id_ex_mem_read = 1'b0; bus.id_ex_rt = 5'd0; bus.if_id_rs = 5'd0; bus.if_id_rt = 5'd0;
    bus.branch_taken = 1'b0; bus.branch_target = 11'd0; bus.halt_detected = 1'b0;
    bus.step_mode = 1'b0; bus.step_pulse = 1'b0;
  endtask

  // asynchronous reset pulse between clock edges; entered and left on a falling edge
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1;
    m_mode = M_FREE; m_cycles = 0; m_stalls = 0;
    checks++; if (bus.cycle_count !== 16'd0) begin errors++; $display("FAIL rst_cycle got %0d exp 0", bus.cycle_count); end
    checks++; if (bus.stall_count !== 16'd0) begin errors++; $display("FAIL rst_stall got %0d exp 0", bus.stall_count); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %0b exp 0", bus.halted); end
    checks++; if (bus4.stall_count !== 4'd0) begin errors++; $display("FAIL rst_stall4 got %0d exp 0", bus4.stall_count); end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    m_mode = M_FREE; m_cycles = 0; m_stalls = 0;
    #3;
    checks++; if (bus.cycle_count !== 16'd0) begin errors++; $display("FAIL init_cycle got %0d exp 0", bus.cycle_count); end
    checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL init_halted got %0b exp 0", bus.halted); end
    @(negedge clock);
    reset_n = 1'b1;
    settle();
    checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL init_pc_write got %0b exp 1", bus.pc_write); end
  endtask

  task automatic test_normal();
    clear_inputs();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      settle();
      checks++; if (bus.pc_write !== 1'b1 || bus.if_id_write !== 1'b1)
        begin errors++; $display("FAIL normal_write cyc %0d got %0b%0b exp 11", i, bus.pc_write, bus.if_id_write); end
      tick();
    end
    settle();
    checks++; if (bus.cycle_count !== 16'd10) begin errors++; $display("FAIL normal_cycles got %0d exp 10", bus.cycle_count); end
    checks++; if (bus.stall_count !== 16'd0) begin errors++; $display("FAIL normal_stalls got %0d exp 0", bus.stall_count); end
  endtask

  task automatic test_load_use();
    clear_inputs();
    bus.id_ex_mem_read = 1'b1; bus.id_ex_rt = 5'd5; bus.if_id_rs = 5'd5; bus.if_id_rt = 5'd7;
    settle();
    checks++; if (bus.pc_write !== 1'b0 || bus.if_id_write !== 1'b0 || bus.id_ex_bubble !== 1'b1)
      begin errors++; $display("FAIL lu_stall got pw=%0b iw=%0b bb=%0b exp 0 0 1", bus.pc_write, bus.if_id_write, bus.id_ex_bubble); end
    tick();
    clear_inputs();
    settle();
    checks++; if (bus.stall_count !== 16'd1) begin errors++; $display("FAIL lu_count got %0d exp 1", bus.stall_count); end
    bus.id_ex_mem_read = 1'b1; bus.id_ex_rt = 5'd0; bus.if_id_rs = 5'd0; bus.if_id_rt = 5'd0;
    settle();
    checks++; if (bus.pc_write !== 1'b1 || bus.id_ex_bubble !== 1'b0)
      begin errors++; $display("FAIL lu_r0 got pw=%0b bb=%0b exp 1 0", bus.pc_write, bus.id_ex_bubble); end
    tick();
    settle();
    checks++; if (bus.stall_count !== 16'd1) begin errors++; $display("FAIL lu_r0_count got %0d exp 1", bus.stall_count); end
  endtask

  task automatic test_branch();
    clear_inputs();
    bus.id_ex_mem_read = 1'b1; bus.id_ex_rt = 5'd9; bus.if_id_rt = 5'd9;
    bus.branch_taken = 1'b1; bus.branch_target = 11'h2A4;
    settle();
    checks++; if (bus.salto_sel !== 1'b1 || bus.if_flush !== 1'b1 || bus.pc_write !== 1'b1 || bus.id_ex_bubble !== 1'b0)
      begin errors++; $display("FAIL br_ctrl got ss=%0b fl=%0b pw=%0b bb=%0b exp 1 1 1 0", bus.salto_sel, bus.if_flush, bus.pc_write, bus.id_ex_bubble); end
    checks++; if (bus.pc_salto !== 11'h2A4) begin errors++; $display("FAIL br_target got %h exp 2a4", bus.pc_salto); end
    tick();
    bus.branch_taken = 1'b0;
    settle();
    checks++; if (bus.stall_count !== e_stall16) begin errors++; $display("FAIL br_stalls got %0d exp %0d", bus.stall_count, e_stall16); end
    checks++; if (bus.pc_salto !== 11'd0) begin errors++; $display("FAIL br_idle_target got %h exp 0", bus.pc_salto); end
  endtask

  task automatic test_halt();
    logic [15:0] frozen;
    clear_inputs();
    bus.halt_detected = 1'b1; bus.branch_taken = 1'b1; bus.branch_target = 11'h155;
    settle();
    checks++; if (bus.salto_sel !== 1'b0 || bus.pc_write !== 1'b0 || bus.id_ex_bubble !== 1'b1 || bus.halted !== 1'b0)
      begin errors++; $display("FAIL halt_entry got ss=%0b pw=%0b bb=%0b h=%0b exp 0 0 1 0", bus.salto_sel, bus.pc_write, bus.id_ex_bubble, bus.halted); end
    tick();
    clear_inputs();
    bus.step_pulse = 1'b1;
    settle();
    frozen = e_cycle;
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++; if (bus.halted !== 1'b1 || bus.pc_write !== 1'b0 || bus.cycle_count !== frozen)
        begin errors++; $display("FAIL halt_hold cyc %0d got h=%0b pw=%0b cnt=%0d exp 1 0 %0d", i, bus.halted, bus.pc_write, bus.cycle_count, frozen); end
      tick();
    end
    clear_inputs();
    do_reset();
    settle();
    checks++; if (bus.pc_write !== 1'b1 || bus.halted !== 1'b0)
      begin errors++; $display("FAIL halt_exit got pw=%0b h=%0b exp 1 0", bus.pc_write, bus.halted); end
  endtask

  task automatic test_step();
    int moves;
    clear_inputs();
    do_reset();
    bus.step_mode = 1'b1;
    settle();
    checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL step_enter got %0b exp 1", bus.pc_write); end
    tick();
    moves = 0;
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) begin settle(); moves += int'(bus.pc_write); tick(); end
      bus.step_pulse = 1'b1;
      settle(); moves += int'(bus.pc_write); tick();
      bus.step_pulse = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin settle(); moves += int'(bus.pc_write); tick(); end
    checks++; if (moves !== 3) begin errors++; $display("FAIL step_count got %0d exp 3", moves); end
    bus.step_mode = 1'b0;
    settle(); tick();
    settle();
    checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL step_exit got %0b exp 1", bus.pc_write); end
    // abandon a granted step via reset
    bus.step_mode = 1'b1; tick(); bus.step_pulse = 1'b1; tick(); bus.step_pulse = 1'b0;
    bus.step_mode = 1'b0;
    do_reset();
    settle(); tick(); settle();
    checks++; if (bus.pc_write !== 1'b1) begin errors++; $display("FAIL step_reset got %0b exp 1", bus.pc_write); end
  endtask

  task automatic test_saturation();
    clear_inputs();
    do_reset();
    bus.id_ex_mem_read = 1'b1; bus.id_ex_rt = 5'd3; bus.if_id_rs = 5'd3;
    for (int i = 0; i < 20; i++) tick();
    settle();
    checks++; if (bus4.stall_count !== 4'd15) begin errors++; $display("FAIL sat_stall4 got %0d exp 15", bus4.stall_count); end
    checks++; if (bus.stall_count !== 16'd20) begin errors++; $display("FAIL sat_stall16 got %0d exp 20", bus.stall_count); end
    checks++; if (bus4.cycle_count !== 4'd15) begin errors++; $display("FAIL sat_cycle4 got %0d exp 15", bus4.cycle_count); end
  endtask

  task automatic test_random();
    int halt_age;
    clear_inputs();
    do_reset();
    halt_age = 0;
    for (int n = 0; n < 600; n++) begin
      bus.id_ex_mem_read = ($urandom_range(0, 1) == 1);
      bus.id_ex_rt       = 5'($urandom_range(0, 3));
      bus.if_id_rs       = 5'($urandom_range(0, 3));
      bus.if_id_rt       = 5'($urandom_range(0, 3));
      bus.branch_taken   = ($urandom_range(0, 4) == 0);
      bus.branch_target  = 11'($urandom_range(0, 2047));
      bus.halt_detected  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) bus.step_mode = ~bus.step_mode;
      bus.step_pulse     = ($urandom_range(0, 3) == 0);
      settle();
      checks++; if ({bus.pc_write, bus.if_id_write, bus.if_flush, bus.salto_sel, bus.id_ex_bubble} !==
                    {e_pc_write, e_if_id_write, e_if_flush, e_salto_sel, e_bubble})
        begin errors++; $display("FAIL rnd_ctrl n=%0d got %b exp %b", n,
          {bus.pc_write, bus.if_id_write, bus.if_flush, bus.salto_sel, bus.id_ex_bubble},
          {e_pc_write, e_if_id_write, e_if_flush, e_salto_sel, e_bubble}); end
      checks++; if (bus.pc_salto !== e_pc_salto) begin errors++; $display("FAIL rnd_target n=%0d got %h exp %h", n, bus.pc_salto, e_pc_salto); end
      checks++; if (bus.halted !== e_halted) begin errors++; $display("FAIL rnd_halted n=%0d got %0b exp %0b", n, bus.halted, e_halted); end
      checks++; if (bus.cycle_count !== e_cycle) begin errors++; $display("FAIL rnd_cycle n=%0d got %0d exp %0d", n, bus.cycle_count, e_cycle); end
      checks++; if (bus.stall_count !== e_stall16 || bus4.stall_count !== e_stall4)
        begin errors++; $display("FAIL rnd_stall n=%0d got %0d/%0d exp %0d/%0d", n, bus.stall_count, bus4.stall_count, e_stall16, e_stall4); end
      tick();
      halt_age = (m_mode == M_HALT) ? halt_age + 1 : 0;
      if (halt_age > 4 || $urandom_range(0, 99) == 0) begin
        do_reset();
        halt_age = 0;
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_normal();
    test_load_use();
    test_branch();
    test_halt();
    test_step();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
